// File: rtl/midi_tx_scheduler_if.sv
// Handshake and message bus between the track scheduler and midi_note_sender.
// The scheduler drives the message fields and trigger; the sender returns busy.
interface midi_tx_scheduler_if;
    logic       trigger;
    logic [3:0] channel;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       sender_busy;

    modport master (output trigger, channel, note, velocity, input sender_busy);
    modport slave  (input trigger, channel, note, velocity, output sender_busy);
endinterface

// File: rtl/midi_tx_scheduler.sv
// Shares one midi_note_sender between sequencer tracks: latches note-on requests,
// schedules gate-length note-offs and arbitrates round-robin with note-offs first.
module midi_tx_scheduler #(
    parameter int         NUM_TRACKS   = 4,
    parameter int         GATE_TICKS   = 2,
    parameter logic [3:0] BASE_CHANNEL = 4'd0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [NUM_TRACKS-1:0]         req,
    input  logic [7*NUM_TRACKS-1:0]       req_note,
    input  logic [7*NUM_TRACKS-1:0]       req_velocity,
    midi_tx_scheduler_if.master           snd,
    output logic [$clog2(NUM_TRACKS)-1:0] grant_idx,
    output logic                          active,
    output logic [NUM_TRACKS-1:0]         overrun
);
    // state       | meaning
    // S_IDLE      | pick next message: pending note-offs first, round-robin from rr_ptr
    // S_ISSUE     | one-cycle trigger to the sender
    // S_WAIT_BUSY | waiting for the sender to raise busy
    // S_WAIT_DONE | waiting for the sender to drop busy
    localparam int IDXW = $clog2(NUM_TRACKS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            channel_q, channel_d;
    logic [6:0]            note_q, note_d;
    logic [6:0]            velocity_q, velocity_d;
    logic [IDXW-1:0]       grant_idx_q, grant_idx_d;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  active_q, active_d;
    logic [NUM_TRACKS-1:0] overrun_q, overrun_d;
    logic [NUM_TRACKS-1:0] on_pend_q, on_pend_d;
    logic [NUM_TRACKS-1:0] off_pend_q, off_pend_d;
    logic [NUM_TRACKS-1:0] gate_run_q, gate_run_d;
    logic [6:0]            on_note_q [NUM_TRACKS];
    logic [6:0]            on_note_d [NUM_TRACKS];
    logic [6:0]            on_vel_q  [NUM_TRACKS];
    logic [6:0]            on_vel_d  [NUM_TRACKS];
    logic [6:0]            off_note_q [NUM_TRACKS];
    logic [6:0]            off_note_d [NUM_TRACKS];
    logic [7:0]            gate_cnt_q [NUM_TRACKS];
    logic [7:0]            gate_cnt_d [NUM_TRACKS];

    logic [NUM_TRACKS-1:0] grant_on, grant_off;
    logic [IDXW:0]         off_pick, on_pick;
    logic [IDXW-1:0]       sel;

    // Returns {found, index} of the first set flag at or after ptr, wrapping.
    function automatic logic [IDXW:0] pick_rr(input logic [NUM_TRACKS-1:0] pend,
                                               input logic [IDXW-1:0] ptr);
        logic [IDXW:0] r;
        int            j;
        r = '0;
        for (int k = NUM_TRACKS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_TRACKS;
            if (pend[IDXW'(j)]) r = {1'b1, IDXW'(j)};
        end
        return r;
    endfunction

    assign off_pick = pick_rr(off_pend_q, rr_ptr_q);
    assign on_pick  = pick_rr(on_pend_q, rr_ptr_q);

    always_comb begin
        state_d     = state_q;
        channel_d   = channel_q;
        note_d      = note_q;
        velocity_d  = velocity_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        active_d    = active_q;
        overrun_d   = overrun_q;
        on_pend_d   = on_pend_q;
        off_pend_d  = off_pend_q;
        gate_run_d  = gate_run_q;
        on_note_d   = on_note_q;
        on_vel_d    = on_vel_q;
        off_note_d  = off_note_q;
        gate_cnt_d  = gate_cnt_q;
        grant_on    = '0;
        grant_off   = '0;
        sel         = '0;

        case (state_q)
            S_IDLE: begin
                if (off_pick[IDXW] || on_pick[IDXW]) begin
                    sel         = off_pick[IDXW] ? off_pick[IDXW-1:0] : on_pick[IDXW-1:0];
                    grant_idx_d = sel;
                    channel_d   = BASE_CHANNEL + 4'(sel);
                    active_d    = 1'b1;
                    state_d     = S_ISSUE;
                    if (off_pick[IDXW]) begin
                        note_d         = off_note_q[sel];
                        velocity_d     = 7'd0;
                        grant_off[sel] = 1'b1;
                    end else begin
                        note_d        = on_note_q[sel];
                        velocity_d    = on_vel_q[sel];
                        grant_on[sel] = 1'b1;
                    end
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (snd.sender_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (!snd.sender_busy) begin
                    active_d = 1'b0;
                    rr_ptr_d = (grant_idx_q == IDXW'(NUM_TRACKS - 1)) ? '0 : grant_idx_q + IDXW'(1);
                    state_d  = S_IDLE;
                end
            end
            default:     state_d = S_IDLE;
        endcase

        // Clears from this cycle's grant come first so fresh events win over them.
        for (int t = 0; t < NUM_TRACKS; t++) begin
            if (grant_off[t]) off_pend_d[t] = 1'b0;
            if (grant_on[t])  on_pend_d[t]  = 1'b0;
            if (gate_run_q[t] && tick) begin
                gate_cnt_d[t] = gate_cnt_q[t] - 8'd1;
                if (gate_cnt_q[t] == 8'd1) begin
                    gate_run_d[t] = 1'b0;
                    off_pend_d[t] = 1'b1;
                end
            end
            if (req[t]) begin
                on_note_d[t] = req_note[7*t +: 7];
                on_vel_d[t]  = req_velocity[7*t +: 7];
                on_pend_d[t] = 1'b1;
                if (on_pend_q[t] && !grant_on[t]) overrun_d[t] = 1'b1;
                if (gate_run_q[t]) begin
                    gate_run_d[t] = 1'b0;
                    off_pend_d[t] = 1'b1;
                end
            end
            if (grant_on[t]) begin
                off_note_d[t] = on_note_q[t];
                gate_cnt_d[t] = 8'(GATE_TICKS);
                gate_run_d[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            channel_q   <= '0;
            note_q      <= '0;
            velocity_q  <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            active_q    <= 1'b0;
            overrun_q   <= '0;
            on_pend_q   <= '0;
            off_pend_q  <= '0;
            gate_run_q  <= '0;
            on_note_q   <= '{default: '0};
            on_vel_q    <= '{default: '0};
            off_note_q  <= '{default: '0};
            gate_cnt_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            channel_q   <= channel_d;
            note_q      <= note_d;
            velocity_q  <= velocity_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            active_q    <= active_d;
            overrun_q   <= overrun_d;
            on_pend_q   <= on_pend_d;
            off_pend_q  <= off_pend_d;
            gate_run_q  <= gate_run_d;
            on_note_q   <= on_note_d;
            on_vel_q    <= on_vel_d;
            off_note_q  <= off_note_d;
            gate_cnt_q  <= gate_cnt_d;
        end
    end

    assign snd.trigger  = (state_q == S_ISSUE);
    assign snd.channel  = channel_q;
    assign snd.note     = note_q;
    assign snd.velocity = velocity_q;
    assign grant_idx    = grant_idx_q;
    assign active       = active_q;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Bench for midi_tx_scheduler: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model of pending notes, gates and sender timing.
module tb_midi_tx_scheduler;
    localparam int N    = 4;
    localparam int GATE = 2;
    localparam int BASE = 0;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tick = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_note = '0;
    logic [7*N-1:0] req_velocity = '0;
    logic [1:0]     grant_idx;
    logic           active;
    logic [N-1:0]   overrun;

    midi_tx_scheduler_if snd ();

    midi_tx_scheduler #(
        .NUM_TRACKS  (N),
        .GATE_TICKS  (GATE),
        .BASE_CHANNEL(4'(BASE))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req         (req),
        .req_note    (req_note),
        .req_velocity(req_velocity),
        .snd         (snd.master),
        .grant_idx   (grant_idx),
        .active      (active),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: pending work per track, remaining gate ticks (0 = no gate), and the
    // cycle of the last grant (m_g) with the sender busy length chosen for it (m_L).
    bit m_on_pend [N];
    int m_on_note [N];
    int m_on_vel  [N];
    bit m_off_pend[N];
    int m_off_note[N];
    int m_gate    [N];
    bit m_ovr     [N];
    int m_rr = 0, m_ready = 0, m_g = -1000, m_L = 0;
    int m_ch = 0, m_note = 0, m_vel = 0, m_idx = 0;
    int tb_note[N];
    int tb_vel [N];
    int lat_force = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model(input logic [N-1:0] r, input bit tk, input bit rs);
        bit old_on[N];
        int old_gate[N];
        int gon, goff, s;
        if (rs) begin
            for (int t = 0; t < N; t++) begin
                m_on_pend[t] = 0; m_on_note[t] = 0; m_on_vel[t] = 0;
                m_off_pend[t] = 0; m_off_note[t] = 0; m_gate[t] = 0; m_ovr[t] = 0;
            end
            m_rr = 0; m_ready = cyc + 1; m_g = -1000; m_L = 0;
            m_ch = 0; m_note = 0; m_vel = 0; m_idx = 0;
            return;
        end
        old_on = m_on_pend;
        old_gate = m_gate;
        gon = -1;
        goff = -1;
        if (cyc >= m_ready) begin
            for (int k = 0; k < N; k++) begin
                s = (m_rr + k) % N;
                if (m_off_pend[s]) begin goff = s; break; end
            end
            if (goff < 0)
                for (int k = 0; k < N; k++) begin
                    s = (m_rr + k) % N;
                    if (m_on_pend[s]) begin gon = s; break; end
                end
            if (goff >= 0 || gon >= 0) begin
                s = (goff >= 0) ? goff : gon;
                m_g = cyc;
                m_L = (lat_force > 0) ? lat_force : int'($urandom_range(2, 8));
                m_ready = cyc + m_L + 3;
                m_rr = (s + 1) % N;
                m_idx = s;
                m_ch = (BASE + s) % 16;
                if (goff >= 0) begin
                    m_note = m_off_note[s]; m_vel = 0; m_off_pend[s] = 0;
                end else begin
                    m_note = m_on_note[s]; m_vel = m_on_vel[s]; m_on_pend[s] = 0;
                end
            end
        end
        for (int t = 0; t < N; t++) begin
            if (tk && old_gate[t] > 0) begin
                m_gate[t] = old_gate[t] - 1;
                if (m_gate[t] == 0) m_off_pend[t] = 1;
            end
            if (r[t]) begin
                if (old_on[t] && gon != t) m_ovr[t] = 1;
                m_on_pend[t] = 1;
                m_on_note[t] = tb_note[t];
                m_on_vel[t] = tb_vel[t];
                if (old_gate[t] > 0) begin
                    m_gate[t] = 0;
                    m_off_pend[t] = 1;
                end
            end
        end
        if (gon >= 0) begin
            m_off_note[gon] = m_note;
            m_gate[gon] = GATE;
        end
    endtask

    task automatic step(input logic [N-1:0] r, input bit tk, input bit rs);
        int ovr_exp;
        @(negedge clk);
        check("trigger", int'(snd.trigger), int'(cyc == m_g + 1));
        check("active", int'(active), int'(cyc >= m_g + 1 && cyc <= m_g + 2 + m_L));
        check("channel", int'(snd.channel), m_ch);
        check("note", int'(snd.note), m_note);
        check("velocity", int'(snd.velocity), m_vel);
        check("grant_idx", int'(grant_idx), m_idx);
        ovr_exp = 0;
        for (int t = 0; t < N; t++) if (m_ovr[t]) ovr_exp |= (1 << t);
        check("overrun", int'(overrun), ovr_exp);
        req = r;
        tick = tk;
        rst = rs;
        for (int t = 0; t < N; t++) begin
            req_note[7*t +: 7] = 7'(tb_note[t]);
            req_velocity[7*t +: 7] = 7'(tb_vel[t]);
        end
        snd.sender_busy = (cyc >= m_g + 2 && cyc <= m_g + 1 + m_L);
        model(r, tk, rs);
        cyc++;
    endtask

    task automatic run(input int n, input int tp);
        for (int i = 0; i < n; i++) step('0, (tp > 0) && (i % tp == tp - 1), 1'b0);
    endtask

    task automatic set_note(input int t, input int n, input int v);
        tb_note[t] = n;
        tb_vel[t] = v;
    endtask

    initial begin
        snd.sender_busy = 1'b0;
        for (int t = 0; t < N; t++) begin
            m_on_pend[t] = 0; m_on_note[t] = 0; m_on_vel[t] = 0;
            m_off_pend[t] = 0; m_off_note[t] = 0; m_gate[t] = 0; m_ovr[t] = 0;
            tb_note[t] = 0; tb_vel[t] = 0;
        end
        repeat (3) step('0, 1'b0, 1'b1);

        // note-on, 10-cycle busy, then gate expiry note-off
        lat_force = 10;
        set_note(0, 60, 100);
        step(4'b0001, 1'b0, 1'b0);
        run(60, 6);

        // two tracks requesting together
        lat_force = 4;
        set_note(1, 40, 50);
        set_note(2, 41, 51);
        step(4'b0110, 1'b0, 1'b0);
        run(40, 0);
        run(20, 3);

        // retrigger cuts the gate: note-off 60 before note-on 62
        set_note(0, 60, 90);
        step(4'b0001, 1'b0, 1'b0);
        run(15, 0);
        step('0, 1'b1, 1'b0);
        run(3, 0);
        set_note(0, 62, 91);
        step(4'b0001, 1'b0, 1'b0);
        run(60, 7);

        // double request while the sender is busy gives overrun
        lat_force = 10;
        set_note(2, 30, 31);
        step(4'b0100, 1'b0, 1'b0);
        set_note(3, 70, 71);
        step(4'b1000, 1'b0, 1'b0);
        set_note(3, 72, 73);
        step(4'b1000, 1'b0, 1'b0);
        run(60, 5);

        // off on track 2 beats on on track 0 with rr pointer at 0
        lat_force = 6;
        set_note(2, 20, 21);
        step(4'b0100, 1'b0, 1'b0);
        run(15, 0);
        set_note(3, 22, 23);
        step(4'b1000, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        set_note(0, 24, 25);
        step(4'b0001, 1'b0, 1'b0);
        run(60, 4);

        // reset while waiting for the sender to finish
        lat_force = 10;
        set_note(0, 50, 51);
        set_note(1, 52, 53);
        step(4'b0011, 1'b0, 1'b0);
        run(6, 0);
        step('0, 1'b0, 1'b1);
        run(30, 4);

        // random traffic
        lat_force = 0;
        for (int i = 0; i < 2500; i++) begin
            logic [N-1:0] r;
            bit tk, rs;
            for (int t = 0; t < N; t++) begin
                r[t] = ($urandom_range(0, 11) == 0);
                tb_note[t] = int'($urandom_range(0, 127));
                tb_vel[t] = int'($urandom_range(1, 127));
            end
            tk = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 599) == 0);
            if (rs) r = '0;
            step(r, tk, rs);
        end
        run(40, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
